pwm_sequencer: RTL

Memory-mapped controller for the LED analog/digital output selector. It generates the shared PWM waveform from a programmable 8-bit duty. It also steps through a table of channel masks, each held for a programmed time, and writes each mask into the selector's mode register (bit = 1 puts that LED on PWM). It sits on the core's peripheral bus beside the selector and drives the selector's `WD`/`WE` write port and `PWM` input.

---
 rtl/pwm_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pwm_sequencer.sv
// rtl/pwm_sequencer.sv - PWM generator and timed channel-mask sequencer for the LED output selector
module pwm_sequencer #(
   parameter int N_OUTPUTS = 16,
   parameter int N_STEPS   = 4,
   parameter int PRESCALE  = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           addr,
   input  logic [31:0]          WD,
   input  logic                 WE,
   output logic [31:0]          RD,
   output logic [N_OUTPUTS-1:0] sel_WD,
   output logic                 sel_WE,
   output logic                 PWM
);

   localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

   state_t               state, next_state;
   logic [SW-1:0]        step, next_step;
   logic                 run, loop_en;
   logic [7:0]           duty, duty_shadow, pwm_cnt;
   logic [15:0]          step_len;
   logic [N_OUTPUTS-1:0] pattern [N_STEPS];
   logic [PW-1:0]        presc;
   logic [15:0]          ticks;
   logic [16:0]          len_eff;
   logic                 tick, step_end;
   logic                 unused_wd;

   assign unused_wd = ^WD;

   // Register file; DONE's clear of RUN is placed last so it beats a same-cycle write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run      <= 1'b0;
         loop_en  <= 1'b0;
         duty     <= '0;
         step_len <= '0;
         for (int k = 0; k < N_STEPS; k++) pattern[k] <= '0;
      end else begin
         if (WE) begin
            case (addr)
               4'd0: begin
                  run     <= WD[0];
                  loop_en <= WD[1];
               end
               4'd1:    duty     <= WD[7:0];
               4'd2:    step_len <= WD[15:0];
               default: ;
            endcase
            for (int k = 0; k < N_STEPS; k++) begin
               if (addr == 4'(4 + k)) pattern[k] <= WD[N_OUTPUTS-1:0];
            end
         end
         if (state == DONE) run <= 1'b0;
      end
   end

   // Shadow reloads only at the wrap so a duty change never cuts a period short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt     <= '0;
         duty_shadow <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (pwm_cnt == 8'hFF) duty_shadow <= duty;
      end
   end

   assign PWM = (pwm_cnt < duty_shadow);

   assign len_eff  = (step_len == 16'd0) ? 17'd1 : {1'b0, step_len};
   assign tick     = (presc == PW'(PRESCALE - 1));
   assign step_end = (state == HOLD) && tick && (({1'b0, ticks} + 17'd1) >= len_eff);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         ticks <= '0;
      end else if (state == LOAD) begin
         presc <= '0;
         ticks <= '0;
      end else if (state == HOLD) begin
         if (tick) begin
            presc <= '0;
            ticks <= ticks + 16'd1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         step  <= '0;
      end else begin
         state <= next_state;
         step  <= next_step;
      end
   end

   always_comb begin
      next_state = state;
      next_step  = step;
      case (state)
         IDLE: begin
            if (run) begin
               next_state = LOAD;
               next_step  = '0;
            end
         end
         LOAD: next_state = run ? HOLD : DONE;
         HOLD: begin
            if (!run) begin
               next_state = DONE;
            end else if (step_end) begin
               if (step != SW'(N_STEPS - 1)) begin
                  next_step  = step + 1'b1;
                  next_state = LOAD;
               end else if (loop_en) begin
                  next_step  = '0;
                  next_state = LOAD;
               end else begin
                  next_state = DONE;
               end
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      sel_WE = (state == LOAD) || (state == DONE);
      sel_WD = '0;
      if (state == LOAD) sel_WD = pattern[step];
   end

   always_comb begin
      RD = '0;
      case (addr)
         4'd0: begin
            RD[0]   = run;
            RD[1]   = loop_en;
            RD[2]   = (state != IDLE);
            RD[6:4] = 3'(step);
         end
         4'd1:    RD[7:0]  = duty;
         4'd2:    RD[15:0] = step_len;
         default: ;
      endcase
      for (int k = 0; k < N_STEPS; k++) begin
         if (addr == 4'(4 + k)) RD[N_OUTPUTS-1:0] = pattern[k];
      end
   end

endmodule
